// File: rtl/cnn_out_pkg.sv
// cnn_out_pkg: types and helpers shared by the CNN output stages
// (the class-sum accumulator and the argmax comparator).
//   state_t     : output FSM states
//   N_CLASSES   : number of classes
//   SUM_WIDTH   : width of the per-class sums presented downstream
//   sat_narrow  : clamps a wide signed value into a dw-bit signed range
package cnn_out_pkg;

  typedef enum logic {
    ACCUM   = 1'b0,
    PRESENT = 1'b1
  } state_t;

  localparam int N_CLASSES = 10;
  localparam int SUM_WIDTH = 16;

  // The value is carried in 64 bits so one function serves any accumulator
  // width. The caller truncates the result to dw bits; once clamped it fits.
  function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] acc,
                                                    input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (acc > hi) begin
      sat_narrow = hi;
    end else if (acc < lo) begin
      sat_narrow = lo;
    end else begin
      sat_narrow = acc;
    end
  endfunction

endpackage

// File: rtl/sat_add.sv
// sat_add: one signed accumulator lane.
// Build option: SUM_SATURATE_EN defined -> the add saturates at the
// ACC_WIDTH signed limits; undefined -> the add wraps modulo 2^ACC_WIDTH.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   add_en   : add addend into the accumulator this cycle
//   clr      : clear the accumulator to 0. Never coincides with add_en
//              in this design.
//   addend   : signed DATA_WIDTH value, sign-extended before the add
//   acc      : registered ACC_WIDTH signed accumulator
module sat_add #(
  parameter int ACC_WIDTH  = 24,
  parameter int DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         add_en,
  input  logic                         clr,
  input  logic signed [DATA_WIDTH-1:0] addend,
  output logic signed [ACC_WIDTH-1:0]  acc
);

  logic signed [ACC_WIDTH-1:0] ext;
  logic signed [ACC_WIDTH-1:0] nxt;

  assign ext = ACC_WIDTH'(addend);

`ifdef SUM_SATURATE_EN
  // Add with one guard bit. If the top two bits differ, the signed add overflowed.
  logic signed [ACC_WIDTH:0] wide;
  assign wide = (ACC_WIDTH + 1)'(acc) + (ACC_WIDTH + 1)'(ext);

  always_comb begin
    nxt = wide[ACC_WIDTH-1:0];
    if (wide[ACC_WIDTH] != wide[ACC_WIDTH-1]) begin
      nxt = wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH - 1){1'b0}}}
                            : {1'b0, {(ACC_WIDTH - 1){1'b1}}};
    end
  end
`else
  assign nxt = acc + ext;
`endif

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (add_en) begin
      acc <= nxt;
    end
  end

endmodule

// File: rtl/class_sum_accumulator.sv
// class_sum_accumulator: keeps one running sum per class of signed partial
// products. After the last beat of an image it presents the whole sum
// vector to the argmax comparator with a valid/ready handshake, then clears.
// Build option: SUM_SATURATE_EN (saturating adds and clamped outputs;
// when undefined, adds wrap and outputs are truncated).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : beat handshake
//   in_data             : signed partial product
//   in_class            : target class. A value >= N_MATS is flagged and
//                         not accumulated.
//   in_last             : final beat of the current image
//   sum[N_MATS]         : per-class sums, signed, derived from registers
//   out_valid/out_ready : sum vector handshake
//   class_err           : sticky out-of-range class flag, cleared by rst
//
// state   | meaning
// ACCUM   | accepting beats, accumulating per class
// PRESENT | sum vector valid, input stalled until out_ready
module class_sum_accumulator import cnn_out_pkg::*; #(
  parameter  int DATA_WIDTH = SUM_WIDTH,
  parameter  int N_MATS     = N_CLASSES,
  parameter  int ACC_WIDTH  = 24,
  localparam int CLS_W      = (N_MATS > 1) ? $clog2(N_MATS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic [CLS_W-1:0]             in_class,
  input  logic                         in_last,
  output logic signed [DATA_WIDTH-1:0] sum [N_MATS-1:0],
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         class_err
);

  state_t state;
  state_t state_nxt;
  logic   accept;
  logic   clear;
  logic   bad_class;
  logic signed [ACC_WIDTH-1:0] acc [N_MATS-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && in_last) begin
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = ACCUM;
        end
      end
    endcase
  end

  assign accept    = in_valid && in_ready;
  assign clear     = out_valid && out_ready;
  assign bad_class = 32'(in_class) >= N_MATS;

  always_ff @(posedge clk) begin
    if (rst) begin
      class_err <= 1'b0;
    end else if (accept && bad_class) begin
      class_err <= 1'b1;
    end
  end

  // An out-of-range class matches no lane, so it is dropped without any
  // extra gating.
  for (genvar i = 0; i < N_MATS; i++) begin : g_lane
    sat_add #(
      .ACC_WIDTH (ACC_WIDTH),
      .DATA_WIDTH(DATA_WIDTH)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .add_en(accept && (in_class == CLS_W'(i))),
      .clr   (clear),
      .addend(in_data),
      .acc   (acc[i])
    );
  end

  // sum depends only on the accumulator flops. This keeps the vector stable
  // while PRESENT stalls, and it is valid in the first PRESENT cycle.
  always_comb begin
    for (int i = 0; i < N_MATS; i++) begin
`ifdef SUM_SATURATE_EN
      sum[i] = DATA_WIDTH'(sat_narrow(64'(acc[i]), DATA_WIDTH));
`else
      sum[i] = DATA_WIDTH'(acc[i]);
`endif
    end
  end

endmodule

// File: tb/tb_class_sum_accumulator.sv
module tb_class_sum_accumulator;
  localparam int DW = 16;
  localparam int NM = 10;
  localparam int AW = 24;
  localparam int CW = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] in_data = '0;
  logic [CW-1:0]        in_class = '0;
  logic                 in_last = 1'b0;
  logic signed [DW-1:0] sum [NM-1:0];
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic                 class_err;

  class_sum_accumulator dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_class (in_class),
    .in_last  (in_last),
    .sum      (sum),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .class_err(class_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [DW-1:0] s [NM];
    logic          err;
  } vec_t;

  vec_t   sb [$];
  longint macc [NM];
  logic   merr = 1'b0;

  function automatic longint fit_acc(input longint v);
    longint half;
    longint span;
    half = longint'(1) << (AW - 1);
    span = half * 2;
`ifdef SUM_SATURATE_EN
    if (v > half - 1) return half - 1;
    if (v < -half) return -half;
    return v;
`else
    v = v % span;
    if (v < 0) v += span;
    if (v >= half) v -= span;
    return v;
`endif
  endfunction

  function automatic logic [DW-1:0] to_out(input longint v);
`ifdef SUM_SATURATE_EN
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
`endif
    return v[DW-1:0];
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NM; i++) macc[i] = 0;
    merr = 1'b0;
    sb.delete();
  endfunction

  function automatic void model_beat(input int cls, input logic [DW-1:0] d, input logic last);
    vec_t e;
    if (cls < NM) macc[cls] = fit_acc(macc[cls] + longint'($signed(d)));
    else merr = 1'b1;
    if (last) begin
      for (int i = 0; i < NM; i++) e.s[i] = to_out(macc[i]);
      e.err = merr;
      sb.push_back(e);
      for (int i = 0; i < NM; i++) macc[i] = 0;
    end
  endfunction

  // ---------------- out_ready driver ----------------
  logic ready_mode  = 1'b0;
  logic ready_force = 1'b1;

  always @(posedge clk) begin
    #1;
    out_ready = ready_mode ? ($urandom_range(0, 2) != 0) : ready_force;
  end

  // ---------------- monitor / scoreboard ----------------
  logic          mon_en  = 1'b0;
  logic          hold_prev = 1'b0;
  logic          last_prev = 1'b0;
  logic          hs_prev   = 1'b0;
  logic [DW-1:0] prev_sum [NM];

  always @(negedge clk) begin
    if (mon_en) begin
      if (hold_prev) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < NM; i++)
          chk($sformatf("hold_sum[%0d]", i), 64'($unsigned(sum[i])), 64'(prev_sum[i]));
      end
      if (last_prev) chk("last_to_valid", 64'(out_valid), 64'd1);
      if (hs_prev) begin
        chk("post_hs_valid", 64'(out_valid), 64'd0);
        chk("post_hs_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < NM; i++)
          chk($sformatf("post_hs_sum[%0d]", i), 64'($unsigned(sum[i])), 64'd0);
      end
      if (out_valid) chk("in_ready_in_present", 64'(in_ready), 64'd0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_vector", 64'd1, 64'd0);
        end else begin
          vec_t e;
          e = sb.pop_front();
          for (int i = 0; i < NM; i++)
            chk($sformatf("sum[%0d]", i), 64'($unsigned(sum[i])), 64'(e.s[i]));
          chk("class_err", 64'(class_err), 64'(e.err));
        end
      end
      hold_prev = out_valid && !out_ready;
      last_prev = in_valid && in_ready && in_last;
      hs_prev   = out_valid && out_ready;
      for (int i = 0; i < NM; i++) prev_sum[i] = sum[i];
    end else begin
      hold_prev = 1'b0;
      last_prev = 1'b0;
      hs_prev   = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic send_beat(input int cls, input logic [DW-1:0] d, input logic last,
                           input int gap, output int waits);
    logic r;
    logic accepted;
    in_valid = 1'b1;
    in_data  = d;
    in_class = CW'(cls);
    in_last  = last;
    waits    = 0;
    accepted = 1'b0;
    while (!accepted && waits < 300) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      waits++;
      if (r) accepted = 1'b1;
      #1;
    end
    if (!accepted) chk("beat_timeout", 64'd0, 64'd1);
    else model_beat(cls, d, last);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "time limit");
  end

  initial begin
    int w;
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_class_err", 64'(class_err), 64'd0);
    for (int i = 0; i < NM; i++)
      chk($sformatf("rst_sum[%0d]", i), 64'($unsigned(sum[i])), 64'd0);
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // basic sums, out_ready high
    send_beat(0, 16'd5, 1'b0, 0, w);
    send_beat(3, 16'd7, 1'b0, 0, w);
    send_beat(0, 16'hFFFE, 1'b0, 0, w);
    send_beat(9, 16'd1, 1'b1, 0, w);
    repeat (3) begin @(posedge clk); #1; end

    // backpressure: hold out_ready low for 5 PRESENT cycles with a beat waiting
    ready_force = 1'b0;
    @(posedge clk);
    #1;
    send_beat(5, 16'd100, 1'b0, 0, w);
    send_beat(5, 16'hFFCE, 1'b0, 0, w);
    send_beat(7, 16'd3, 1'b1, 0, w);
    in_valid = 1'b1;
    in_class = CW'(1);
    in_data  = 16'd11;
    in_last  = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
    end
    ready_force = 1'b1;
    send_beat(1, 16'd11, 1'b0, 0, w);
    chk("pending_accept_latency", 64'(w), 64'd2);
    send_beat(1, 16'd4, 1'b1, 1, w);

    // four max-positive beats to one class
    for (int k = 0; k < 4; k++) send_beat(2, 16'h7FFF, k == 3, 0, w);
    repeat (2) begin @(posedge clk); #1; end

    // drive one accumulator past its limit, then pull it back
    for (int k = 0; k < 300; k++) send_beat(1, 16'h7FFF, 1'b0, 0, w);
    for (int k = 0; k < 256; k++) send_beat(1, 16'h8000, k == 255, 0, w);
    repeat (2) begin @(posedge clk); #1; end

    // out-of-range class closing an image
    send_beat(12, 16'h1234, 1'b1, 2, w);

    // randomized images with random out_ready and gaps
    ready_mode = 1'b1;
    for (int img = 0; img < 40; img++) begin
      int len;
      len = $urandom_range(1, 8);
      for (int b = 0; b < len; b++) begin
        int            cls;
        logic [DW-1:0] d;
        cls = ($urandom_range(0, 19) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
        if ($urandom_range(0, 3) == 0) d = DW'($urandom);
        else d = DW'(int'($urandom_range(0, 200)) - 100);
        send_beat(cls, d, b == len - 1, $urandom_range(0, 2), w);
      end
    end
    for (int k = 0; k < 500 && sb.size() != 0; k++) @(posedge clk);
    chk("drain", 64'(sb.size()), 64'd0);

    // reset while presenting
    ready_mode  = 1'b0;
    ready_force = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    send_beat(3, 16'h0042, 1'b1, 0, w);
    @(negedge clk);
    chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
    chk("pre_rst_class_err", 64'(class_err), 64'(merr));
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_class_err", 64'(class_err), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < NM; i++)
      chk($sformatf("mid_rst_sum[%0d]", i), 64'($unsigned(sum[i])), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
